// File: rtl/hex_pkg.sv
// Shared types for the hex processor memory subsystem: address/data widths,
// loader state encoding and the word-index type used by the memory and loader.
package hex_pkg;

  localparam int ADDR_W            = 18;
  localparam int MEM_WORDS_DEFAULT = 65536;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [ADDR_W-3:0] word_idx_t;
  typedef logic [ADDR_W:0]   byte_cnt_t;
  typedef logic [7:0]        instr_t;
  typedef logic [31:0]       data_t;

  typedef enum logic [1:0] {
    SIZE,
    LOAD,
    DONE,
    ERROR
  } ld_state_t;

endpackage

// File: rtl/hex_loader.sv
// Streaming image loader: a 4-byte little-endian length header followed by N
// image bytes, emitted as byte writes; holds the processor in reset until done.
module hex_loader
  import hex_pkg::*;
#(
  parameter int MEM_WORDS = MEM_WORDS_DEFAULT
) (
  input  logic      i_clk,
  input  logic      i_rst,
  input  logic      i_ld_valid,
  input  logic [7:0] i_ld_byte,
  output logic      o_ld_ready,
  output logic      o_cpu_rst,
  output logic      o_ld_done,
  output logic      o_ld_error,
  output logic      o_wr_en,
  output word_idx_t o_wr_word,
  output logic [1:0] o_wr_lane,
  output logic [7:0] o_wr_byte
);

  localparam logic [31:0] CAP_BYTES = 32'(4 * MEM_WORDS);

  ld_state_t   state_q;
  logic [31:0] size_q;
  logic [1:0]  hdr_cnt_q;
  byte_cnt_t   byte_cnt_q;
  logic        cpu_rst_q;
  logic        done_q;
  logic        error_q;

  logic        hs;
  logic        last_byte;
  logic [31:0] size_full;

  // Ready comes straight from the state so the first header byte is taken on
  // the very first edge after reset release.
  assign o_ld_ready = !i_rst && (state_q == SIZE || state_q == LOAD);
  assign hs         = i_ld_valid && o_ld_ready;
  assign size_full  = {i_ld_byte, size_q[23:0]};
  assign last_byte  = (32'(byte_cnt_q) == size_q - 32'd1);

  assign o_wr_en   = hs && (state_q == LOAD);
  assign o_wr_word = byte_cnt_q[ADDR_W-1:2];
  assign o_wr_lane = byte_cnt_q[1:0];
  assign o_wr_byte = i_ld_byte;

  assign o_cpu_rst  = cpu_rst_q;
  assign o_ld_done  = done_q;
  assign o_ld_error = error_q;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= SIZE;
      size_q     <= '0;
      hdr_cnt_q  <= '0;
      byte_cnt_q <= '0;
      cpu_rst_q  <= 1'b1;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else if (hs) begin
      case (state_q)
        SIZE: begin
          size_q[8*hdr_cnt_q +: 8] <= i_ld_byte;
          hdr_cnt_q                <= hdr_cnt_q + 2'd1;
          if (hdr_cnt_q == 2'd3) begin
            if (size_full > CAP_BYTES) begin
              state_q <= ERROR;
              error_q <= 1'b1;
            end else if (size_full == 32'd0) begin
              state_q   <= DONE;
              done_q    <= 1'b1;
              cpu_rst_q <= 1'b0;
            end else begin
              state_q <= LOAD;
            end
          end
        end
        LOAD: begin
          byte_cnt_q <= byte_cnt_q + 1'b1;
          if (last_byte) begin
            state_q   <= DONE;
            done_q    <= 1'b1;
            cpu_rst_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/hex_memory.sv
// Unified program/data memory serving a byte fetch port and a word data port.
// Define HEX_MEMORY_LOADER_EN to load the image over i_ld_*.
module hex_memory
  import hex_pkg::*;
#(
  parameter int    MEM_WORDS = MEM_WORDS_DEFAULT,
  parameter string INIT_FILE = ""
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_f_valid,
  input  addr_t      i_f_addr,
  output instr_t     o_f_data,
  input  logic       i_d_valid,
  input  logic       i_d_we,
  input  addr_t      i_d_addr,
  input  data_t      i_d_data,
  output data_t      o_d_data,
  input  logic       i_ld_valid,
  output logic       o_ld_ready,
  input  logic [7:0] i_ld_byte,
  output logic       o_cpu_rst,
  output logic       o_ld_done,
  output logic       o_ld_error
);

  localparam int IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  data_t     mem [MEM_WORDS];

  word_idx_t f_word;
  word_idx_t d_word;
  logic      f_in_range;
  logic      d_in_range;
  logic      cpu_rst;
  logic      st_en;
  data_t     f_rd_word;

  logic       ld_wr_en;
  word_idx_t  ld_word;
  logic [1:0] ld_lane;
  logic [7:0] ld_byte;

`ifdef HEX_MEMORY_LOADER_EN
  hex_loader #(
    .MEM_WORDS (MEM_WORDS)
  ) u_loader (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_ld_valid (i_ld_valid),
    .i_ld_byte  (i_ld_byte),
    .o_ld_ready (o_ld_ready),
    .o_cpu_rst  (cpu_rst),
    .o_ld_done  (o_ld_done),
    .o_ld_error (o_ld_error),
    .o_wr_en    (ld_wr_en),
    .o_wr_word  (ld_word),
    .o_wr_lane  (ld_lane),
    .o_wr_byte  (ld_byte)
  );
`else
  logic cpu_rst_q;
  logic unused_ld;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) cpu_rst_q <= 1'b1;
    else       cpu_rst_q <= 1'b0;
  end

  assign cpu_rst    = cpu_rst_q;
  assign o_ld_ready = 1'b0;
  assign o_ld_error = 1'b0;
  assign o_ld_done  = ~i_rst;
  assign ld_wr_en   = 1'b0;
  assign ld_word    = '0;
  assign ld_lane    = '0;
  assign ld_byte    = '0;
  assign unused_ld  = ^{i_ld_valid, i_ld_byte};
`endif

  assign o_cpu_rst = cpu_rst;

  assign f_word     = i_f_addr[ADDR_W-1:2];
  assign d_word     = i_d_addr[ADDR_W-1:2];
  assign f_in_range = (32'(f_word) < 32'(MEM_WORDS));
  assign d_in_range = (32'(d_word) < 32'(MEM_WORDS));
  assign st_en      = i_d_valid && i_d_we && !cpu_rst && d_in_range;

  // NOTE: the storage array has no reset; contents deliberately survive i_rst.
  always_ff @(posedge i_clk) begin
    if (ld_wr_en) mem[ld_word[IDX_W-1:0]][8*ld_lane +: 8] <= ld_byte;
    else if (st_en) mem[d_word[IDX_W-1:0]] <= i_d_data;
  end

  // Reads are zero-latency; a same-cycle store is seen only after its edge.
  always_comb begin
    f_rd_word = mem[f_word[IDX_W-1:0]];
    o_f_data  = '0;
    o_d_data  = '0;
    if (!cpu_rst && f_in_range) o_f_data = f_rd_word[8*i_f_addr[1:0] +: 8];
    if (!cpu_rst && d_in_range) o_d_data = mem[d_word[IDX_W-1:0]];
  end

  logic unused_in;
  assign unused_in = ^{i_f_valid, i_d_addr[1:0], ld_word};

endmodule

// File: tb/tb_hex_memory.sv
// Self-checking bench for hex_memory: reset state, loader image sequences
// (when HEX_MEMORY_LOADER_EN is defined), a directed vector table and random ops.
module tb_hex_memory;
  import hex_pkg::*;

  localparam int MW = 256;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic       i_f_valid;
  addr_t      i_f_addr;
  instr_t     o_f_data;
  logic       i_d_valid;
  logic       i_d_we;
  addr_t      i_d_addr;
  data_t      i_d_data;
  data_t      o_d_data;
  logic       i_ld_valid;
  logic       o_ld_ready;
  logic [7:0] i_ld_byte;
  logic       o_cpu_rst;
  logic       o_ld_done;
  logic       o_ld_error;

  int checks = 0;
  int errors = 0;

  data_t model [MW];

  typedef struct {
    logic   v;
    logic   we;
    addr_t  da;
    data_t  dd;
    addr_t  fa;
    data_t  exp_d;
    instr_t exp_f;
  } vec_t;

  vec_t vecs [11];

  always #5 i_clk = ~i_clk;

  hex_memory #(.MEM_WORDS(MW)) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_f_valid  (i_f_valid),
    .i_f_addr   (i_f_addr),
    .o_f_data   (o_f_data),
    .i_d_valid  (i_d_valid),
    .i_d_we     (i_d_we),
    .i_d_addr   (i_d_addr),
    .i_d_data   (i_d_data),
    .o_d_data   (o_d_data),
    .i_ld_valid (i_ld_valid),
    .o_ld_ready (o_ld_ready),
    .i_ld_byte  (i_ld_byte),
    .o_cpu_rst  (o_cpu_rst),
    .o_ld_done  (o_ld_done),
    .o_ld_error (o_ld_error)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  function automatic data_t model_word(input addr_t a);
    int idx;
    idx = int'(a >> 2);
    return (idx < MW) ? model[idx] : '0;
  endfunction

  function automatic instr_t model_byte(input addr_t a);
    data_t w;
    w = model_word(a) >> (8 * int'(a[1:0]));
    return w[7:0];
  endfunction

  task automatic rd(input addr_t a, output data_t d);
    i_d_addr = a;
    #1;
    d = o_d_data;
  endtask

  // One data-port/fetch-port cycle: outputs checked mid-cycle, model updated after the edge.
  task automatic op(input logic v, input logic we, input addr_t da, input data_t dd,
                    input addr_t fa, input data_t exp_d, input instr_t exp_f, input string name);
    int idx;
    i_d_valid = v;
    i_d_we    = we;
    i_d_addr  = da;
    i_d_data  = dd;
    i_f_addr  = fa;
    @(negedge i_clk);
    check({name, " d"}, o_d_data, exp_d);
    check({name, " f"}, 32'(o_f_data), 32'(exp_f));
    tick();
    idx = int'(da >> 2);
    if (v && we && idx < MW) model[idx] = dd;
    i_d_valid = 1'b0;
    i_d_we    = 1'b0;
  endtask

`ifdef HEX_MEMORY_LOADER_EN
  task automatic send(input logic [7:0] b);
    i_ld_valid = 1'b1;
    i_ld_byte  = b;
    tick();
  endtask

  task automatic do_reset();
    i_ld_valid = 1'b0;
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
  endtask

  task automatic loader_tests();
    data_t      w;
    logic [7:0] nb [8];

    // Basic load, starting on the cycle reset is released.
    send(8'h04); send(8'h00); send(8'h00); send(8'h00);
    send(8'hAA); send(8'hBB); send(8'hCC);
    check("basic cpu_rst before last byte", 32'(o_cpu_rst), 32'd1);
    send(8'hDD);
    i_ld_valid = 1'b0;
    check("basic cpu_rst after 8 cycles", 32'(o_cpu_rst), 32'd0);
    check("basic done", 32'(o_ld_done), 32'd1);
    check("basic ready", 32'(o_ld_ready), 32'd0);
    rd(18'h0, w);
    check("basic word0", w, 32'hDDCCBBAA);
    i_f_addr = 18'h2;
    #1;
    check("basic fetch addr2", 32'(o_f_data), 32'h000000CC);

    // Seed word 1 so the partial-word load can show untouched lanes.
    i_d_valid = 1'b1; i_d_we = 1'b1; i_d_addr = 18'h4; i_d_data = 32'hA5A5A5A5;
    tick();
    i_d_valid = 1'b0; i_d_we = 1'b0;

    do_reset();
    send(8'h05); send(8'h00); send(8'h00); send(8'h00);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44); send(8'h55);
    i_ld_valid = 1'b0;
    rd(18'h0, w);
    check("partial word0", w, 32'h44332211);
    rd(18'h4, w);
    check("partial word1", w, 32'hA5A5A555);
    check("partial done", 32'(o_ld_done), 32'd1);
    check("partial ready", 32'(o_ld_ready), 32'd0);

    // Zero size: DONE right after the header, no memory write.
    i_d_valid = 1'b1; i_d_we = 1'b1; i_d_addr = 18'h0; i_d_data = 32'h13572468;
    tick();
    i_d_valid = 1'b0; i_d_we = 1'b0;
    do_reset();
    send(8'h00); send(8'h00); send(8'h00);
    check("zero done before 4th", 32'(o_ld_done), 32'd0);
    send(8'h00);
    i_ld_valid = 1'b0;
    check("zero done", 32'(o_ld_done), 32'd1);
    check("zero cpu_rst", 32'(o_cpu_rst), 32'd0);
    rd(18'h0, w);
    check("zero word0 untouched", w, 32'h13572468);

    // Oversize: 4*MW+1 = 1025 bytes.
    do_reset();
    send(8'h01); send(8'h04); send(8'h00); send(8'h00);
    check("oversize error", 32'(o_ld_error), 32'd1);
    check("oversize cpu_rst", 32'(o_cpu_rst), 32'd1);
    check("oversize ready", 32'(o_ld_ready), 32'd0);
    send(8'h77); send(8'h88); send(8'h99);
    i_ld_valid = 1'b0;
    check("oversize stays error", 32'(o_ld_error), 32'd1);
    check("oversize no done", 32'(o_ld_done), 32'd0);
    check("oversize ready held", 32'(o_ld_ready), 32'd0);

    // Reset mid-load, then a fresh 8-byte image.
    do_reset();
    send(8'h0C); send(8'h00); send(8'h00); send(8'h00); send(8'h01); send(8'h02);
    do_reset();
    check("midload cpu_rst after reset", 32'(o_cpu_rst), 32'd1);
    for (int i = 0; i < 8; i++) nb[i] = 8'($urandom);
    send(8'h08); send(8'h00); send(8'h00); send(8'h00);
    for (int i = 0; i < 7; i++) send(nb[i]);
    check("midload cpu_rst before last", 32'(o_cpu_rst), 32'd1);
    send(nb[7]);
    i_ld_valid = 1'b0;
    check("midload cpu_rst released", 32'(o_cpu_rst), 32'd0);
    rd(18'h0, w);
    check("midload word0", w, {nb[3], nb[2], nb[1], nb[0]});
    rd(18'h4, w);
    check("midload word1", w, {nb[7], nb[6], nb[5], nb[4]});
  endtask
`endif

  initial begin
    data_t w;
    logic  v, we;
    addr_t da, fa;
    data_t dd;

    i_rst = 1'b1; i_f_valid = 1'b0; i_f_addr = '0; i_d_valid = 1'b0; i_d_we = 1'b0;
    i_d_addr = '0; i_d_data = '0; i_ld_valid = 1'b0; i_ld_byte = '0;
    repeat (2) @(posedge i_clk);
    #1;
    check("reset cpu_rst", 32'(o_cpu_rst), 32'd1);
    check("reset ld_done", 32'(o_ld_done), 32'd0);
    check("reset ld_error", 32'(o_ld_error), 32'd0);
    check("reset ld_ready", 32'(o_ld_ready), 32'd0);
    check("reset d_data forced 0", o_d_data, 32'd0);
    check("reset f_data forced 0", 32'(o_f_data), 32'd0);
    i_rst     = 1'b0;
    i_f_valid = 1'b1;

`ifdef HEX_MEMORY_LOADER_EN
    check("release ld_ready", 32'(o_ld_ready), 32'd1);
    loader_tests();
`else
    check("release cpu_rst before edge", 32'(o_cpu_rst), 32'd1);
    check("release ld_ready", 32'(o_ld_ready), 32'd0);
    tick();
    check("run cpu_rst", 32'(o_cpu_rst), 32'd0);
    check("run ld_done", 32'(o_ld_done), 32'd1);
    check("run ld_error", 32'(o_ld_error), 32'd0);
`endif

    // Fill every word with a recognisable pattern through the store port.
    for (int i = 0; i < MW; i++) begin
      i_d_valid = 1'b1; i_d_we = 1'b1;
      i_d_addr = addr_t'(i * 4); i_d_data = data_t'(i) * 32'h01010101;
      tick();
      model[i] = data_t'(i) * 32'h01010101;
    end
    i_d_valid = 1'b0; i_d_we = 1'b0;

    vecs = '{
      '{1'b1, 1'b1, 18'h00103, 32'h12345678, 18'h00101, 32'h40404040, 8'h40},
      '{1'b1, 1'b0, 18'h00100, 32'h0,        18'h00101, 32'h12345678, 8'h56},
      '{1'b1, 1'b0, 18'h00102, 32'h0,        18'h00103, 32'h12345678, 8'h12},
      '{1'b1, 1'b1, 18'h00000, 32'hDDCCBBAA, 18'h00000, 32'h00000000, 8'h00},
      '{1'b1, 1'b1, 18'h00400, 32'hFFFFFFFF, 18'h00002, 32'h00000000, 8'hCC},
      '{1'b0, 1'b0, 18'h00000, 32'h0,        18'h00003, 32'hDDCCBBAA, 8'hDD},
      '{1'b1, 1'b1, 18'h003FF, 32'h0BADF00D, 18'h003FC, 32'hFFFFFFFF, 8'hFF},
      '{1'b1, 1'b0, 18'h003FC, 32'h0,        18'h003FF, 32'h0BADF00D, 8'h0B},
      '{1'b0, 1'b1, 18'h00004, 32'h0,        18'h00400, 32'h01010101, 8'h00},
      '{1'b1, 1'b0, 18'h00004, 32'h0,        18'h00005, 32'h01010101, 8'h01},
      '{1'b1, 1'b0, 18'h3FFFC, 32'h0,        18'h3FFFF, 32'h00000000, 8'h00}
    };
    for (int i = 0; i < 11; i++)
      op(vecs[i].v, vecs[i].we, vecs[i].da, vecs[i].dd, vecs[i].fa,
         vecs[i].exp_d, vecs[i].exp_f, $sformatf("vec%0d", i));

    for (int i = 0; i < 400; i++) begin
      v  = ($urandom_range(0, 3) != 0);
      we = 1'($urandom);
      da = addr_t'($urandom_range(0, 32'h4FF));
      dd = $urandom;
      fa = addr_t'($urandom_range(0, 32'h4FF));
      op(v, we, da, dd, fa, model_word(da), model_byte(fa), $sformatf("rand%0d", i));
    end

    // Stores during processor reset are ignored; contents survive i_rst.
    i_rst = 1'b1;
    i_d_valid = 1'b1; i_d_we = 1'b1; i_d_addr = 18'h0000C; i_d_data = ~model[3];
    tick();
    check("persist cpu_rst in reset", 32'(o_cpu_rst), 32'd1);
    check("persist d_data forced 0", o_d_data, 32'd0);
    i_rst = 1'b0;
`ifdef HEX_MEMORY_LOADER_EN
    send(8'h00); send(8'h00); send(8'h00); send(8'h00);
    i_ld_valid = 1'b0;
`else
    tick();
`endif
    i_d_valid = 1'b0; i_d_we = 1'b0;
    check("persist cpu_rst released", 32'(o_cpu_rst), 32'd0);
    rd(18'h0000C, w);
    check("persist word3", w, model[3]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
